// File: rtl/jhash_pkg.sv
// Shared constants, rotation tables and FSM encoding for the lookup3 stream hasher.
package jhash_pkg;

  localparam logic [31:0] JH_INIT = 32'hDEADBEEF;

  localparam logic [3:0] MIX_STEPS = 4'd6;
  localparam logic [3:0] FIN_STEPS = 4'd7;

  // Left-rotation amounts, entry 0 in the least significant slice.
  localparam logic [29:0] MIX_ROT = {5'd4, 5'd19, 5'd16, 5'd8, 5'd6, 5'd4};
  localparam logic [34:0] FIN_ROT = {5'd24, 5'd14, 5'd4, 5'd16, 5'd25, 5'd11, 5'd14};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MIX   = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } jh_state_e;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] r);
    return (x << r) | (x >> (6'd32 - {1'b0, r}));
  endfunction

  function automatic logic [4:0] step_rot(input logic fin, input logic [2:0] idx);
    logic [4:0] r;
    r = 5'd0;
    case (idx)
      3'd0: r = fin ? FIN_ROT[4:0]   : MIX_ROT[4:0];
      3'd1: r = fin ? FIN_ROT[9:5]   : MIX_ROT[9:5];
      3'd2: r = fin ? FIN_ROT[14:10] : MIX_ROT[14:10];
      3'd3: r = fin ? FIN_ROT[19:15] : MIX_ROT[19:15];
      3'd4: r = fin ? FIN_ROT[24:20] : MIX_ROT[24:20];
      3'd5: r = fin ? FIN_ROT[29:25] : MIX_ROT[29:25];
      3'd6: r = FIN_ROT[34:30];
      default: r = 5'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jhash_step.sv
// One lookup3 mix or final sub-step; passes a/b/c through unchanged when not enabled.
module jhash_step
  import jhash_pkg::*;
(
  input  logic        en,
  input  logic        fin,
  input  logic [2:0]  idx,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic [31:0] a_n,
  output logic [31:0] b_n,
  output logic [31:0] c_n
);

  logic [1:0]  sel;
  logic [4:0]  r;
  logic [31:0] x, y, z, xn, zn;

  // Both step families cycle their roles through (a,b,c) -> (b,c,a) -> (c,a,b).
  always_comb begin
    case (idx)
      3'd0, 3'd3, 3'd6: sel = 2'd0;
      3'd1, 3'd4:       sel = 2'd1;
      default:          sel = 2'd2;
    endcase
    r = step_rot(fin, idx);
    case (sel)
      2'd0:    begin x = a; y = b; z = c; end
      2'd1:    begin x = b; y = c; z = a; end
      default: begin x = c; y = a; z = b; end
    endcase
    if (fin) begin
      xn = x;
      zn = (z ^ y) - rotl(y, r);
    end else begin
      xn = (x - z) ^ rotl(z, r);
      zn = z + y;
    end
    a_n = a;
    b_n = b;
    c_n = c;
    if (en) begin
      case (sel)
        2'd0:    begin a_n = xn; c_n = zn; end
        2'd1:    begin b_n = xn; a_n = zn; end
        default: begin c_n = xn; b_n = zn; end
      endcase
    end
  end

endmodule

// File: rtl/jhash_stream.sv
// Streaming lookup3 hashlittle2: one key at a time, 32-bit little-endian data words,
// UNROLL mix/final sub-steps per cycle.
//
// state | meaning
// IDLE  | waiting for a key command
// LOAD  | collecting up to three words of the current 12-byte block
// MIX   | running the six mix sub-steps after a full block
// FINAL | running the seven final sub-steps after the tail block
// DONE  | result held until out_ready
module jhash_stream
  import jhash_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int MAX_LEN = 1024,
  parameter int UNROLL  = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      cmd_seed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_hash,
  output logic [31:0]      out_hash2,
  output logic             out_err
);

  jh_state_e        state;
  logic [31:0]      a, b, c, k0, k1, k2;
  logic [LEN_W-1:0] rem;
  logic [1:0]       widx;
  logic [2:0]       step;

  logic [31:0] init;
  logic        too_long, full_blk, last_word, busy, seq_end;
  logic [1:0]  nw;
  logic [31:0] kn0, kn1, kn2;
  logic [95:0] bmask, blk;
  logic [3:0]  nsteps, step_nx;
  logic [31:0] ca [UNROLL+1];
  logic [31:0] cb [UNROLL+1];
  logic [31:0] cc [UNROLL+1];

  assign cmd_ready = (state == IDLE);
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DONE);

  assign init     = JH_INIT + 32'(cmd_len) + cmd_seed;
  assign too_long = 32'(cmd_len) > 32'(MAX_LEN);
  assign full_blk = rem > LEN_W'(12);
  assign nw       = (rem > LEN_W'(8)) ? 2'd3 : (rem > LEN_W'(4)) ? 2'd2 : 2'd1;
  assign last_word = (widx == nw - 2'd1);

  // Current word merged into the block, then bytes past the key end zeroed.
  always_comb begin
    kn0 = k0;
    kn1 = k1;
    kn2 = k2;
    case (widx)
      2'd0:    kn0 = in_data;
      2'd1:    kn1 = in_data;
      default: kn2 = in_data;
    endcase
    for (int i = 0; i < 12; i++) begin
      bmask[i*8 +: 8] = (rem > LEN_W'(i)) ? 8'hFF : 8'h00;
    end
    blk = {kn2, kn1, kn0} & bmask;
  end

  assign busy    = (state == MIX) || (state == FINAL);
  assign nsteps  = (state == FINAL) ? FIN_STEPS : MIX_STEPS;
  assign step_nx = {1'b0, step} + 4'(UNROLL);
  assign seq_end = (step_nx >= nsteps);

  assign ca[0] = a;
  assign cb[0] = b;
  assign cc[0] = c;

  for (genvar j = 0; j < UNROLL; j++) begin : g_step
    logic [3:0] sidx;
    assign sidx = {1'b0, step} + 4'(j);
    jhash_step u_step (
      .en  (busy && (sidx < nsteps)),
      .fin (state == FINAL),
      .idx (sidx[2:0]),
      .a   (ca[j]),
      .b   (cb[j]),
      .c   (cc[j]),
      .a_n (ca[j+1]),
      .b_n (cb[j+1]),
      .c_n (cc[j+1])
    );
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      k0        <= '0;
      k1        <= '0;
      k2        <= '0;
      rem       <= '0;
      widx      <= '0;
      step      <= '0;
      out_hash  <= '0;
      out_hash2 <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          a       <= init;
          b       <= init;
          c       <= init;
          rem     <= cmd_len;
          k0      <= '0;
          k1      <= '0;
          k2      <= '0;
          widx    <= '0;
          step    <= '0;
          out_err <= 1'b0;
          if (too_long) begin
            out_err   <= 1'b1;
            out_hash  <= '0;
            out_hash2 <= '0;
            state     <= DONE;
          end else if (cmd_len == '0) begin
            out_hash  <= init;
            out_hash2 <= init;
            state     <= DONE;
          end else begin
            state <= LOAD;
          end
        end
        LOAD: if (in_valid) begin
          if (last_word) begin
            a    <= a + blk[31:0];
            b    <= b + blk[63:32];
            c    <= c + blk[95:64];
            k0   <= '0;
            k1   <= '0;
            k2   <= '0;
            widx <= '0;
            step <= '0;
            if (full_blk) begin
              rem   <= rem - LEN_W'(12);
              state <= MIX;
            end else begin
              rem   <= '0;
              state <= FINAL;
            end
          end else begin
            k0   <= kn0;
            k1   <= kn1;
            k2   <= kn2;
            widx <= widx + 2'd1;
          end
        end
        MIX, FINAL: begin
          a <= ca[UNROLL];
          b <= cb[UNROLL];
          c <= cc[UNROLL];
          if (seq_end) begin
            step <= '0;
            if (state == FINAL) begin
              out_hash  <= cc[UNROLL];
              out_hash2 <= cb[UNROLL];
              state     <= DONE;
            end else begin
              state <= LOAD;
            end
          end else begin
            step <= step_nx[2:0];
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jhash_stream.sv
// Directed bench for jhash_stream: four instances (UNROLL 2,1,3,7) checked against
// published lookup3 values and a reference hashlittle2 model.
module tb_jhash_stream;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        cmd_valid [4];
  logic        cmd_ready [4];
  logic [15:0] cmd_len   [4];
  logic [31:0] cmd_seed  [4];
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic [31:0] in_data   [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic [31:0] out_hash  [4];
  logic [31:0] out_hash2 [4];
  logic        out_err   [4];

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  logic [7:0] key [64];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int U = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 7;
    jhash_stream #(.LEN_W(16), .MAX_LEN(1024), .UNROLL(U)) u_dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .cmd_valid (cmd_valid[g]),
      .cmd_ready (cmd_ready[g]),
      .cmd_len   (cmd_len[g]),
      .cmd_seed  (cmd_seed[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_hash  (out_hash[g]),
      .out_hash2 (out_hash2[g]),
      .out_err   (out_err[g])
    );
  end

  typedef struct {
    int          unit;
    int          len;
    logic [31:0] seed;
    bit          gaps;
    logic [31:0] exp_c;
    logic [31:0] exp_b;
  } vec_t;

  function automatic int unr(input int u);
    case (u)
      0: return 2;
      1: return 1;
      2: return 3;
      default: return 7;
    endcase
  endfunction

  function automatic int lat_exp(input int u);
    return (7 + unr(u) - 1) / unr(u) + 1;
  endfunction

  function automatic logic [31:0] kword(input int pos);
    return {key[pos+3], key[pos+2], key[pos+1], key[pos]};
  endfunction

  function automatic logic [31:0] kw(input int pos, input int len);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++)
      if (pos + i < len) w[i*8 +: 8] = key[pos+i];
    return w;
  endfunction

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Straight translation of the reference hashlittle2 with a zero secondary seed.
  function automatic logic [63:0] ref_hash(input int len, input logic [31:0] seed);
    logic [31:0] a, b, c;
    int off, r;
    a = 32'hDEADBEEF + 32'(len) + seed;
    b = a;
    c = a;
    off = 0;
    r = len;
    if (len == 0) return {b, c};
    while (r > 12) begin
      a += kw(off, len); b += kw(off + 4, len); c += kw(off + 8, len);
      a -= c; a ^= rl(c, 4);  c += b;
      b -= a; b ^= rl(a, 6);  a += c;
      c -= b; c ^= rl(b, 8);  b += a;
      a -= c; a ^= rl(c, 16); c += b;
      b -= a; b ^= rl(a, 19); a += c;
      c -= b; c ^= rl(b, 4);  b += a;
      r -= 12;
      off += 12;
    end
    a += kw(off, len); b += kw(off + 4, len); c += kw(off + 8, len);
    c ^= b; c -= rl(b, 14);
    a ^= c; a -= rl(c, 11);
    b ^= a; b -= rl(a, 25);
    c ^= b; c -= rl(b, 16);
    a ^= c; a -= rl(c, 4);
    b ^= a; b -= rl(a, 14);
    c ^= b; c -= rl(b, 24);
    return {b, c};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=handshake", nm);
  endtask

  task automatic send_cmd(input int u, input int len, input logic [31:0] seed);
    int n;
    n = 0;
    cmd_len[u]   = 16'(len);
    cmd_seed[u]  = seed;
    cmd_valid[u] = 1'b1;
    while (!cmd_ready[u] && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) timeout("cmd_wait");
    @(negedge CLK);
    cmd_valid[u] = 1'b0;
    cmd_len[u]   = 16'hFFFF;
    cmd_seed[u]  = $urandom;
  endtask

  task automatic send_word(input int u, input logic [31:0] d, input bit gaps, output int t);
    int n;
    n = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid[u] = 1'b0;
        in_data[u]  = $urandom;
        @(negedge CLK);
      end
    end
    in_data[u]  = d;
    in_valid[u] = 1'b1;
    while (!in_ready[u] && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) timeout("data_wait");
    t = cyc_cnt;
    @(negedge CLK);
    in_valid[u] = 1'b0;
    in_data[u]  = $urandom;
  endtask

  task automatic get_result(input int u, output logic [31:0] h, output logic [31:0] h2,
                            output logic e, output int when);
    int n;
    n = 0;
    while (!out_valid[u] && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 300) timeout("out_wait");
    when = cyc_cnt;
    h    = out_hash[u];
    h2   = out_hash2[u];
    e    = out_err[u];
    out_ready[u] = 1'b1;
    @(negedge CLK);
    out_ready[u] = 1'b0;
  endtask

  task automatic run_key(input string nm, input int u, input int len, input logic [31:0] seed,
                         input bit gaps, input logic [31:0] ec, input logic [31:0] eb);
    int t, when;
    logic [31:0] h, h2;
    logic e;
    t = 0;
    send_cmd(u, len, seed);
    for (int w = 0; w < (len + 3) / 4; w++) send_word(u, kword(4 * w), gaps, t);
    get_result(u, h, h2, e, when);
    chk({nm, "_hash"}, h, ec);
    chk({nm, "_hash2"}, h2, eb);
    chk({nm, "_err"}, 32'(e), 32'd0);
    if (len > 0) chk({nm, "_lat"}, 32'(when - t), 32'(lat_exp(u)));
  endtask

  initial begin
    vec_t vt [15];
    logic [63:0] m;
    string phrase;
    int t;

    phrase = "Four score and seven years ago";
    for (int i = 0; i < 64; i++) key[i] = (i < 30) ? phrase[i] : 8'(i * 37 + 11);

    m = ref_hash(30, 32'd0);
    vt[0] = '{0, 0, 32'h0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[1] = '{0, 0, 32'hDEADBEEF, 1'b0, 32'hBD5B7DDE, 32'hBD5B7DDE};
    vt[2] = '{0, 30, 32'h0, 1'b0, 32'h17770551, m[63:32]};
    vt[4] = '{1, 30, 32'h0, 1'b1, 32'h17770551, m[63:32]};
    vt[6] = '{3, 30, 32'h0, 1'b1, 32'h17770551, m[63:32]};
    m = ref_hash(30, 32'd1);
    vt[3] = '{0, 30, 32'h1, 1'b0, 32'hCD628161, m[63:32]};
    vt[5] = '{2, 30, 32'h1, 1'b1, 32'hCD628161, m[63:32]};
    vt[7] = '{3, 30, 32'h1, 1'b1, 32'hCD628161, m[63:32]};
    m = ref_hash(12, 32'h12345678);
    vt[8]  = '{0, 12, 32'h12345678, 1'b0, m[31:0], m[63:32]};
    vt[10] = '{1, 12, 32'h12345678, 1'b1, m[31:0], m[63:32]};
    m = ref_hash(13, 32'h12345678);
    vt[9]  = '{0, 13, 32'h12345678, 1'b0, m[31:0], m[63:32]};
    vt[11] = '{2, 13, 32'h12345678, 1'b1, m[31:0], m[63:32]};
    m = ref_hash(1, 32'h0);
    vt[12] = '{0, 1, 32'h0, 1'b0, m[31:0], m[63:32]};
    m = ref_hash(40, 32'hCAFEBABE);
    vt[13] = '{0, 40, 32'hCAFEBABE, 1'b1, m[31:0], m[63:32]};
    m = ref_hash(25, 32'h0BADF00D);
    vt[14] = '{3, 25, 32'h0BADF00D, 1'b0, m[31:0], m[63:32]};

    RST_N = 1'b0;
    for (int u = 0; u < 4; u++) begin
      cmd_valid[u] = 1'b0; cmd_len[u] = '0; cmd_seed[u] = '0;
      in_valid[u]  = 1'b0; in_data[u] = '0; out_ready[u] = 1'b0;
    end
    repeat (2) @(negedge CLK);
    chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_out_hash", out_hash[0], 32'd0);
    chk("rst_out_hash2", out_hash2[0], 32'd0);
    chk("rst_out_err", 32'(out_err[0]), 32'd0);
    chk("rst_in_ready", 32'(in_ready[0]), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    for (int u = 0; u < 4; u++) chk($sformatf("rst_cmd_ready%0d", u), 32'(cmd_ready[u]), 32'd1);

    for (int i = 0; i < 15; i++)
      run_key($sformatf("v%0d", i), vt[i].unit, vt[i].len, vt[i].seed, vt[i].gaps,
              vt[i].exp_c, vt[i].exp_b);

    // Reset in the middle of the first MIX of a 30-byte key.
    send_cmd(0, 30, 32'd0);
    for (int w = 0; w < 3; w++) send_word(0, kword(4 * w), 1'b0, t);
    chk("mid_mix_in_ready", 32'(in_ready[0]), 32'd0);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_out_hash", out_hash[0], 32'd0);
    chk("mid_rst_out_hash2", out_hash2[0], 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    m = ref_hash(30, 32'd1);
    run_key("post_rst", 0, 30, 32'd1, 1'b0, 32'hCD628161, m[63:32]);

    // Over-length command: error result, held while out_ready stays low.
    send_cmd(0, 1025, 32'd1);
    in_valid[0] = 1'b1;
    in_data[0]  = 32'h5A5A5A5A;
    chk("err_out_valid", 32'(out_valid[0]), 32'd1);
    chk("err_out_err", 32'(out_err[0]), 32'd1);
    chk("err_hash", out_hash[0], 32'd0);
    chk("err_hash2", out_hash2[0], 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk($sformatf("err_hold_valid%0d", k), 32'(out_valid[0]), 32'd1);
      chk($sformatf("err_hold_err%0d", k), 32'(out_err[0]), 32'd1);
      chk($sformatf("err_hold_hash%0d", k), out_hash[0], 32'd0);
      chk($sformatf("err_hold_cmd_ready%0d", k), 32'(cmd_ready[0]), 32'd0);
      chk($sformatf("err_hold_in_ready%0d", k), 32'(in_ready[0]), 32'd0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge CLK);
    out_ready[0] = 1'b0;
    chk("err_after_valid", 32'(out_valid[0]), 32'd0);
    chk("err_after_cmd_ready", 32'(cmd_ready[0]), 32'd1);

    m = ref_hash(13, 32'h0);
    run_key("after_err", 0, 13, 32'h0, 1'b1, m[31:0], m[63:32]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/jhash_stream.md
JHASH_STREAM -- requirements
Module: jhash_stream

Interface
REQ-001 Parameter LEN_W, default 16, width of key-length field in bytes.
REQ-002 Parameter MAX_LEN, default 1024, largest accepted key length in bytes, at most 2^LEN_W-1.
REQ-003 Parameter UNROLL, default 2, mix/final sub-steps evaluated per cycle, legal range 1..7.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low; ports: CLK  in  1  clock; RST_N  in  1  async active-low reset.
REQ-005 Port cmd_valid  in  1  key command offered.
REQ-006 Port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 Port cmd_len  in  LEN_W  key length in bytes.
REQ-008 Port cmd_seed  in  32  initval for this key.
REQ-009 Port in_valid  in  1  data word offered.
REQ-010 Port in_ready  out  1  data word accepted when high with in_valid.
REQ-011 Port in_data  in  32  four key bytes, little-endian (byte 0 in [7:0]).
REQ-012 Port out_valid  out  1  result available.
REQ-013 Port out_ready  in  1  result consumed when high with out_valid.
REQ-014 Port out_hash  out  32  lookup3 primary hash (c).
REQ-015 Port out_hash2  out  32  lookup3 secondary hash (b).
REQ-016 Port out_err  out  1  command rejected, length exceeded MAX_LEN.

Function
REQ-017 The block SHALL compute Bob Jenkins lookup3 hashlittle2 (c and b outputs) over a byte stream, one key in flight.
REQ-018 FSM states SHALL be IDLE, LOAD, MIX, FINAL, DONE; cmd_ready high only in IDLE, in_ready high only in LOAD, out_valid high only in DONE.
REQ-019 On cmd handshake: a=b=c=0xDEADBEEF+cmd_len+cmd_seed (mod 2^32); remaining-byte counter rem=cmd_len; k0..k2 cleared; next state LOAD, or DONE if cmd_len==0 (hash=c, hash2=b, no final), or DONE with out_err=1 and both hashes 0 if cmd_len>MAX_LEN.
REQ-020 LOAD SHALL accept words into k0,k1,k2 in order; block word count = 3 if rem>12, else ceil(rem/4); words beyond count stay zero.
REQ-021 On the last word of a block with rem>12: a+=k0, b+=k1, c+=k2 at that edge, rem-=12, k cleared, state MIX.
REQ-022 On the last word of a block with rem in 1..12: bytes at positions >= rem masked to zero, added likewise, state FINAL.
REQ-023 Mix SHALL be the six lookup3 sub-steps with left rotations 4,6,8,16,19,4; final the seven sub-steps with rotations 14,11,25,16,4,14,24.
REQ-024 MIX SHALL last ceil(6/UNROLL) cycles then return to LOAD; FINAL SHALL last ceil(7/UNROLL) cycles then enter DONE.
REQ-025 If the last data handshake occurs in cycle T, out_valid SHALL first be high in cycle T+ceil(7/UNROLL)+1.
REQ-026 DONE SHALL hold out_* stable until out_ready; on handshake return to IDLE; cmd_ready stays low until then.
REQ-027 in_data and cmd_* SHALL be ignored while the corresponding ready is low; stalls on in_valid SHALL not alter a,b,c.
REQ-028 All arithmetic SHALL be modulo 2^32; rem SHALL never underflow.

Reset
REQ-029 RST_N low SHALL asynchronously force IDLE, a=b=c=k0=k1=k2=0, rem=0, out_valid=0, out_hash=0, out_hash2=0, out_err=0, discarding any key in progress.
REQ-030 After RST_N deasserts, cmd_ready SHALL be high in the first cycle.

Structure
REQ-031 Package jhash_pkg SHALL hold the 0xDEADBEEF constant, mix and final rotation tables, and the FSM state enum.
REQ-032 One sub-module jhash_step SHALL implement a single mix or final sub-step selected by step index; jhash_stream instantiates UNROLL of them in a chain.

Verification
REQ-033 len=0, seed=0 -> out_hash=0xDEADBEEF, out_hash2=0xDEADBEEF, no data beats.
REQ-034 len=0, seed=0xDEADBEEF -> out_hash=0xBD5B7DDE.
REQ-035 "Four score and seven years ago" (30 bytes), seed=0 -> out_hash=0x17770551; seed=1 -> 0xCD628161; repeat with UNROLL 1, 3 and 7 and random in_valid gaps, same results.
REQ-036 len=12 and len=13 keys -> one versus two blocks, match C model; latency per REQ-025.
REQ-037 cmd_len=MAX_LEN+1 -> out_err=1, hashes 0, no in_ready; out_ready held low 5 cycles -> outputs stable, cmd_ready low.
REQ-038 RST_N pulsed low mid-MIX -> outputs zero immediately, next key hashes correctly.
